// File: rtl/ahb_dmem_responder.sv
// ahb_dmem_responder
//   AHB-Lite responder for a word-organised data memory holding 32-bit words
//   with a 7-bit SECDED checksum each. Loads return the raw stored word and
//   checksum (the initiator corrects). Stores are checked against the
//   initiator's write-data checksum; narrow stores are merged against the
//   corrected stored word and re-encoded.
//
//   Ports
//     s_clk_i, s_reset_i         clock, async active-high reset
//     s_hsel_i .. s_hready_i     AHB address-phase inputs (+ 6-bit addr parity)
//     s_hwdata_i, s_hwdcheck_i   write data and its SECDED checksum
//     s_hrdata_o, s_hrdcheck_o   read data and stored checksum (0 when not a read data phase)
//     s_hreadyout_o, s_hresp_o   transfer done / ERROR response
//     s_cerr_o, s_uerr_o         corrected / uncorrectable error pulses during narrow-store merge
//
//   Checksum layout: bits [5:0] are Hamming parities over positions 1..38 with
//   data bits in the non-power-of-two positions; bit 6 is overall parity.

module ahb_dmem_responder #(
    parameter int DEPTH = 1024
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_hsel_i,
    input  logic [31:0] s_haddr_i,
    input  logic [1:0]  s_htrans_i,
    input  logic [2:0]  s_hsize_i,
    input  logic        s_hwrite_i,
    input  logic [5:0]  s_hparity_i,
    input  logic        s_hready_i,
    input  logic [31:0] s_hwdata_i,
    input  logic [6:0]  s_hwdcheck_i,
    output logic [31:0] s_hrdata_o,
    output logic [6:0]  s_hrdcheck_o,
    output logic        s_hreadyout_o,
    output logic        s_hresp_o,
    output logic        s_cerr_o,
    output logic        s_uerr_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    // Codeword position (1..38) of data bit i; powers of two hold check bits.
    function automatic logic [5:0] data_pos(input int i);
        if (i < 1)       return 6'd3;
        else if (i < 4)  return 6'(i + 4);
        else if (i < 11) return 6'(i + 5);
        else if (i < 26) return 6'(i + 6);
        else             return 6'(i + 7);
    endfunction

    function automatic logic [6:0] secded_encode(input logic [31:0] d);
        logic [6:0] c;
        logic [5:0] pos;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            pos = data_pos(i);
            for (int j = 0; j < 6; j++)
                if (pos[j]) c[j] = c[j] ^ d[i];
        end
        c[6] = ^{d, c[5:0]};
        return c;
    endfunction

    // ---------------- address phase ----------------
    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [5:0]    w_par_exp;
    logic          w_aerr;

    assign w_accept = s_hsel_i & s_htrans_i[1] & s_hready_i;
    assign w_idx    = s_haddr_i[AW+1:2];

    always_comb begin
        w_par_exp = '0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < 8; k++)
                w_par_exp[p] = w_par_exp[p] ^ s_haddr_i[p + 4*k];
        w_par_exp[4] = ^s_hsize_i ^ s_hwrite_i;
        w_par_exp[5] = ^s_htrans_i;
    end

    assign w_aerr = (w_par_exp != s_hparity_i)
                  | (|s_haddr_i[31:AW+2])
                  | (s_hsize_i > 3'd2)
                  | ((s_hsize_i == 3'd1) & s_haddr_i[0])
                  | ((s_hsize_i == 3'd2) & (s_haddr_i[1:0] != 2'b00));

    // ---------------- control state ----------------
    state_t        r_state, w_next, w_phase;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [2:0]    r_size;
    logic          r_write;
    logic          r_aerr;
    logic [38:0]   r_word;
    logic [38:0]   r_mem [DEPTH];

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_off   <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_aerr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_off   <= s_haddr_i[1:0];
                r_size  <= s_hsize_i;
                r_write <= s_hwrite_i;
                r_aerr  <= w_aerr;
            end
        end
    end

    // ---------------- old-word decode ----------------
    logic [6:0]  w_old_enc;
    logic [5:0]  w_syn;
    logic        w_ovr;
    logic [31:0] w_cor;
    logic        w_ce, w_ue;

    assign w_old_enc = secded_encode(r_word[31:0]);

    always_comb begin
        w_syn = r_word[37:32] ^ w_old_enc[5:0];
        w_ovr = ^r_word;
        w_cor = r_word[31:0];
        for (int i = 0; i < 32; i++)
            if (w_ovr && (data_pos(i) == w_syn)) w_cor[i] = ~w_cor[i];
        // Odd overall parity = single error unless the syndrome points past
        // the codeword; even parity with a syndrome = double error.
        w_ce = w_ovr & (w_syn <= 6'd38);
        w_ue = (~w_ovr & (w_syn != 6'd0)) | (w_ovr & (w_syn > 6'd38));
    end

    // ---------------- write data phase ----------------
    logic [3:0]  w_lanes;
    logic [31:0] w_merged;
    logic [6:0]  w_newchk;
    logic        w_narrow, w_wdata, w_err, w_we;

    assign w_narrow = (r_size != 3'd2);
    assign w_wdata  = (r_state == DATA) & r_write;

    always_comb begin
        case (r_size)
            3'd0:    w_lanes = 4'b0001 << r_off;
            3'd1:    w_lanes = r_off[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
        w_merged = '0;
        for (int l = 0; l < 4; l++)
            w_merged[8*l +: 8] = w_lanes[l] ? s_hwdata_i[8*l +: 8] : w_cor[8*l +: 8];
    end

    assign w_newchk = secded_encode(w_merged);

    assign w_err = (r_state == DATA)
                 & (r_aerr | (r_write & ((secded_encode(s_hwdata_i) != s_hwdcheck_i)
                                         | (w_narrow & w_ue))));
    assign w_we  = w_wdata & ~w_err;

    assign s_cerr_o = w_wdata & ~r_aerr & w_narrow & w_ce;
    assign s_uerr_o = w_wdata & ~r_aerr & w_narrow & w_ue;

    // Array: one synchronous read port (at acceptance) and one write port.
    // A read of the word being committed this cycle takes the merged value.
    always_ff @(posedge s_clk_i) begin
        if (w_we) r_mem[r_idx] <= {w_newchk, w_merged};
        if (w_accept)
            r_word <= (w_we && (w_idx == r_idx)) ? {w_newchk, w_merged} : r_mem[w_idx];
    end

    // ---------------- FSM ----------------
    // The data-phase cycle of an errored transfer is itself the first ERROR
    // cycle, so the response stays at two cycles total.
    assign w_phase = w_err ? ERR1 : r_state;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_accept ? DATA : IDLE;
            DATA:    w_next = w_err ? ERR2 : (w_accept ? DATA : IDLE);
            ERR1:    w_next = ERR2;
            ERR2:    w_next = w_accept ? DATA : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        s_hreadyout_o = 1'b1;
        s_hresp_o     = 1'b0;
        s_hrdata_o    = '0;
        s_hrdcheck_o  = '0;
        case (w_phase)
            DATA: begin
                if (!r_write) begin
                    s_hrdata_o   = r_word[31:0];
                    s_hrdcheck_o = r_word[38:32];
                end
            end
            ERR1: begin
                s_hreadyout_o = 1'b0;
                s_hresp_o     = 1'b1;
            end
            ERR2: s_hresp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/ahb_dmem_responder.md
# ahb_dmem_responder

AHB-Lite responder fronting a word-organised data memory that stores each 32-bit word with its 7-bit SECDED checksum. It is the bus-side counterpart of the core's load/store initiator. It performs the following checks:
- address-phase parity, which it verifies;
- write-data checksums, which it verifies;
- narrow stores, which it merges internally against the ECC-corrected stored word.

It returns stored data with its raw checksum so the initiator performs EDAC on loads.

## Interface
- DEPTH, 1024, number of 39-bit memory words. Valid byte addresses are 0 to DEPTH*4-1; higher address bits beyond the index are compared against zero.
- s_clk_i  in  1  clock, all state updates on rising edge.
- s_reset_i  in  1  reset, asynchronous, active-high. Resets control state only; the memory array is not reset.
- s_hsel_i  in  1  slave select.
- s_haddr_i  in  32  address.
- s_htrans_i  in  2  transfer type; bit 1 set means NONSEQ/SEQ.
- s_hsize_i  in  3  transfer size.
- s_hwrite_i  in  1  write indicator.
- s_hparity_i  in  6  address-phase parity.
- s_hready_i  in  1  bus-level HREADY.
- s_hwdata_i  in  32  write data, lane-aligned.
- s_hwdcheck_i  in  7  SECDED checksum of the full s_hwdata_i word.
- s_hrdata_o  out  32  read data; 0 outside read data phases.
- s_hrdcheck_o  out  7  stored checksum of s_hrdata_o; 0 outside read data phases.
- s_hreadyout_o  out  1  transfer done.
- s_hresp_o  out  1  ERROR response.
- s_cerr_o  out  1  one-cycle pulse: corrected single error during a narrow-store merge.
- s_uerr_o  out  1  one-cycle pulse: uncorrectable error during a narrow-store merge.

## Operation
- **Acceptance.** An address phase is accepted when s_hsel_i & s_htrans_i[1] & s_hready_i. At acceptance, capture index = haddr[log2(DEPTH)+1:2], byte offset, size and write, and set a pending error flag if any of these hold:
  - parity mismatch;
  - out of range;
  - hsize > 2;
  - misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0.
- **Parity.** For p=0..3, expected[p] = XOR of haddr[p+4k], k=0..7. expected[4] = ^hsize ^ hwrite. expected[5] = ^htrans.
- **Array.** The array has 1 read port and 1 write port, both synchronous to the clock. At acceptance of any transfer, the array is read at the index and the result is registered for the data phase.
- **Forwarding.** If the accepted index equals the index being written in the same cycle, the registered word and checksum come from the write-side merged value, not the array.
- **Read data phase.** Drive the registered word on s_hrdata_o and the stored checksum on s_hrdcheck_o, unmodified. No slave-side correction is applied.
- **Write data phase.**
  - Compute a = secded_encode(s_hwdata_i). If a ≠ s_hwdcheck_i, the transfer takes an ERROR response.
  - Decode the registered old word with the codebase SECDED decode/analyze.
  - Merged word takes hwdata lanes selected by size and offset:
    - byte: lane offset;
    - halfword: lanes 2*addr[1] and 2*addr[1]+1;
    - word: all lanes.
  - All other lanes come from the corrected old word.
  - New checksum = secded_encode(merged).
  - A word store never consults the old word and never raises s_cerr_o or s_uerr_o.
  - A narrow store with a correctable old word pulses s_cerr_o.
  - A narrow store with an uncorrectable old word pulses s_uerr_o and takes an ERROR response.
- **Commit.** The array is written at the end of the write data phase only if no error applies (address-phase or data-phase).
- **FSM states.**
  - IDLE: hreadyout=1, hresp=0.
  - DATA: zero-wait data phase.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- **FSM transitions.**
  - An accepted transfer moves to DATA.
  - DATA with an error goes to ERR1, then ERR2, then IDLE. If ERR2 coincides with a new acceptance, go to DATA instead of IDLE.
  - DATA without error goes to DATA on a new acceptance, otherwise IDLE.
- **Error side effects.** An errored transfer never writes the array, and its read data is driven 0.

## Timing
- **Reset values.** s_hreadyout_o=1, s_hresp_o=0, s_hrdata_o=0, s_hrdcheck_o=0, s_cerr_o=0, s_uerr_o=0, FSM=IDLE, pending error cleared.
- **Reset mid-operation.** Asserting reset mid-transfer or mid-ERROR aborts it. No array write occurs in that cycle.
- **Reads.** Address phase in cycle T, data valid in T+1 with hreadyout=1 (zero wait).
- **Writes.** Address phase in T, hwdata sampled in T+1, array updated at the end of T+1 (zero wait).
- **Errors.** ERROR occupies T+1 (ERR1) and T+2 (ERR2). Total is 2 cycles and 0 array writes.
- **Back-to-back.** A write in its data phase at T+1 followed by a read of the same word accepted at T+1: the read returns the new value at T+2 via forwarding.
- **Pulse timing.** s_cerr_o and s_uerr_o pulse in the write data-phase cycle itself.

## Test plan
- **Word write then read.** Write 0x12345678 to 0x10 with the correct checksum, then read 0x10. Expect hrdata=0x12345678, hrdcheck=encode(0x12345678), hreadyout=1 in every data phase.
- **Narrow stores.** Word 0x11223344 at 0x10, then byte 0xAB written on lane 1 to 0x11, then halfword 0xBEEF written on lanes 2–3 to 0x12. A read of 0x10 returns 0xBEEFAB44 with a matching checksum.
- **Bad write checksum.** Write 0x0 to 0x20 with hwdcheck bit0 flipped. Expect ERR1 then ERR2 (hreadyout 0 then 1, hresp=1 on both), then a read of 0x20 returns the prior content.
- **Address errors.** Each of the following produces a two-cycle ERROR and no array change:
  - flip s_hparity_i[2];
  - address DEPTH*4;
  - hsize=3;
  - halfword at 0x01.
- **Write/read overlap.** Write 0xCAFEF00D to 0x30, immediately followed by a read of 0x30. Expect 0xCAFEF00D in the read data phase; also run write-then-write to the same word with a byte store.
- **Corrupted old word.** Backdoor-flip 1 bit of the word at 0x40, then store a byte: s_cerr_o pulses and a read returns the corrected merged word. Flip 2 bits, then store a byte: s_uerr_o pulses, ERROR is returned, and the word is unchanged. Assert reset during ERR1: hreadyout=1 and hresp=0 immediately.
